// File: rtl/result_vector_serializer.sv
// Result vector serializer: buffers matmul result vectors in a small circular FIFO
// and streams them one element per cycle over valid/ready, flagging dropped vectors.

package config_pkg;
    localparam int D   = 4;
    localparam int FpW = 16;
    typedef logic signed [FpW-1:0] fixed_point_t;
    typedef fixed_point_t [D-1:0] vector_t;
endpackage

module result_vector_serializer
    import config_pkg::*;
#(
    parameter int NumSlots = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  vector_t              vec_i,
    input  logic                 vec_valid_i,
    output logic                 vec_ready_o,
    output fixed_point_t         elem_o,
    output logic [$clog2(D)-1:0] elem_idx_o,
    output logic                 elem_last_o,
    output logic                 elem_valid_o,
    input  logic                 elem_ready_i,
    output logic                 overflow_o,
    input  logic                 clear_overflow_i
);

    localparam int PtrW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int CntW = $clog2(NumSlots + 1);
    localparam int IdxW = $clog2(D);

    localparam logic [PtrW-1:0] LastSlot = PtrW'(NumSlots - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(D - 1);
    localparam logic [CntW-1:0] FullCnt  = CntW'(NumSlots);
    localparam logic [CntW-1:0] OneCnt   = CntW'(1);

    typedef enum logic {
        EMPTY,
        STREAMING
    } state_e;

    state_e          state_q, state_d;
    vector_t         slots_q [NumSlots];
    vector_t         slots_d [NumSlots];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            overflow_q, overflow_d;

    logic full, pop, pop_last, accept, capture, drop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastSlot) ? '0 : p + 1'b1;
    endfunction

    // Handshake and capture decode; a last-element pop frees a slot in the same cycle.
    always_comb begin
        full         = (count_q == FullCnt);
        elem_valid_o = (state_q == STREAMING);
        elem_o       = slots_q[rd_ptr_q][idx_q];
        elem_idx_o   = idx_q;
        elem_last_o  = elem_valid_o && (idx_q == LastIdx);
        pop          = elem_valid_o && elem_ready_i;
        pop_last     = pop && elem_last_o;
        accept       = !full || pop_last;
        capture      = vec_valid_i && accept;
        drop         = vec_valid_i && !accept;
        vec_ready_o  = accept;
        overflow_o   = overflow_q;
    end

    always_comb begin
        state_d    = state_q;
        slots_d    = slots_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;

        if (pop) begin
            if (pop_last) begin
                idx_d    = '0;
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (capture) begin
            slots_d[wr_ptr_q] = vec_i;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end

        count_d = count_q + CntW'(capture) - CntW'(pop_last);

        // Drop wins over a same-cycle clear so a loss is never hidden.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow_i) begin
            overflow_d = 1'b0;
        end

        case (state_q)
            EMPTY: begin
                if (capture) state_d = STREAMING;
            end
            STREAMING: begin
                if (pop_last && !capture && (count_q == OneCnt)) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Slot storage carries no reset; contents are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        slots_q <= slots_d;
    end

endmodule
